// File: rtl/intbus_fifo_target.sv
// intbus_fifo_target: byte-wide write FIFO behind a 4-register intbus window,
// drained through a valid/ready port. Optional sticky overflow: INTBUS_FIFO_OVF_IRQ_EN.
module intbus_fifo_target #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bus_sel,
  input  logic [1:0] bus_addr,
  input  logic [7:0] bus_wrdata,
  input  logic       bus_strobe,
  input  logic       bus_write,
  output logic [7:0] bus_rddata,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_COUNT  = 2'd2,
    REG_CTRL   = 2'd3
  } reg_e;

  logic [7:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DEPTH_LOG2-1:0] thr_q, thr_d;
  logic                  irq_en_q, irq_en_d;
  logic                  out_valid_q, out_valid_d;
  logic                  irq_q, irq_d;
  logic [7:0]            bus_rddata_q, bus_rddata_d;

  logic access, wr_acc, rd_acc;
  logic push, pop, push_ok, flush, ovf_event, ovf_clr;
  logic full, empty, low, ovf;

  assign access  = bus_sel & bus_strobe;
  assign wr_acc  = access & bus_write;
  assign rd_acc  = access & ~bus_write;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign low     = (count_q <= {1'b0, thr_q});

  assign push    = wr_acc & (reg_e'(bus_addr) == REG_DATA);
  assign pop     = out_valid_q & out_ready;
  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  assign push_ok = push & (~full | pop);
  assign flush   = wr_acc & (reg_e'(bus_addr) == REG_CTRL) & bus_wrdata[6];
  assign ovf_event = push & full & ~pop;
  assign ovf_clr   = wr_acc & (reg_e'(bus_addr) == REG_STATUS) & bus_wrdata[5];

`ifdef INTBUS_FIFO_OVF_IRQ_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_event)    ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_event | ovf_clr;
  assign ovf = 1'b0;
`endif

  logic unused_wrdata;
  assign unused_wrdata = &{1'b0, bus_wrdata};

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    irq_en_d = irq_en_q;
    thr_d    = thr_q;
    // The flushing write leaves the rest of CTRL untouched.
    if (wr_acc && reg_e'(bus_addr) == REG_CTRL && !bus_wrdata[6]) begin
      irq_en_d = bus_wrdata[7];
      thr_d    = bus_wrdata[DEPTH_LOG2-1:0];
    end
  end

  always_comb begin
    bus_rddata_d = bus_rddata_q;
    if (rd_acc) begin
      case (reg_e'(bus_addr))
        REG_STATUS: bus_rddata_d = {full, empty, ovf, low, 4'b0000};
        REG_COUNT:  bus_rddata_d = 8'(count_q);
        REG_CTRL:   bus_rddata_d = {irq_en_q, 7'b0} | 8'(thr_q);
        default:    bus_rddata_d = 8'h00;
      endcase
    end
  end

  assign out_valid_d = (count_d != '0);
  assign irq_d       = irq_en_q & (low | ovf);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      thr_q        <= '0;
      irq_en_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      irq_q        <= 1'b0;
      bus_rddata_q <= 8'h00;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      thr_q        <= thr_d;
      irq_en_q     <= irq_en_d;
      out_valid_q  <= out_valid_d;
      irq_q        <= irq_d;
      bus_rddata_q <= bus_rddata_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable through count-gated pops.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr_q] <= bus_wrdata;
  end

  assign out_data   = mem[rd_ptr_q];
  assign out_valid  = out_valid_q;
  assign irq        = irq_q;
  assign bus_rddata = bus_rddata_q;

endmodule
